// File: rtl/fifo_circular.sv
// Single-clock first-word-fall-through circular FIFO with wrap-bit pointers.
// Head word is shown combinationally; a pop acknowledges the word on data_read_out.
module fifo_circular #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     nrst_in,
  input  logic                     write_in,
  input  logic [WIDTH-1:0]         data_write_in,
  input  logic                     read_in,
  output logic [WIDTH-1:0]         data_read_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc_c;
  logic             rd_acc_c;

  // Flags and occupancy derive directly from the registered pointers.
  assign empty_out = (wr_ptr == rd_ptr);
  assign full_out  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count_out = wr_ptr - rd_ptr;

  assign wr_acc_c = write_in && !full_out;
  assign rd_acc_c = read_in && !empty_out;

  assign data_read_out = empty_out ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer state; the wrap bit disambiguates full from empty.
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc_c) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array is intentionally left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem[wr_ptr[AW-1:0]] <= data_write_in;
  end

endmodule

// File: tb/tb_fifo_circular.sv
// Directed self-checking bench for fifo_circular (DEPTH=16, WIDTH=8).
module tb_fifo_circular;

  logic       clk;
  logic       nrst_in;
  logic       write_in;
  logic [7:0] data_write_in;
  logic       read_in;
  logic [7:0] data_read_out;
  logic       full_out;
  logic       empty_out;
  logic [4:0] count_out;

  int errors;
  int checks;
  logic [7:0] fill_v [16];

  fifo_circular #(.DEPTH(16), .WIDTH(8)) dut (
    .clk           (clk),
    .nrst_in       (nrst_in),
    .write_in      (write_in),
    .data_write_in (data_write_in),
    .read_in       (read_in),
    .data_read_out (data_read_out),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .count_out     (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst_in = 1'b0;
    write_in = 1'b0;
    read_in = 1'b0;
    data_write_in = 8'h00;
    step();
    step();
    nrst_in = 1'b1;
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_out); end
    checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_out); end
    checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_out); end
    checks++; if (data_read_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_read_out); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      write_in = 1'b1;
      data_write_in = fill_v[i];
      step();
      if (i == 0) begin
        checks++; if (empty_out !== 1'b0) begin errors++; $display("FAIL fill_first_empty got=%b exp=0", empty_out); end
        checks++; if (data_read_out !== 8'h10) begin errors++; $display("FAIL fill_first_data got=%h exp=10", data_read_out); end
      end
      if (i < 15) begin
        checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL fill_early_full i=%0d got=%b exp=0", i, full_out); end
      end
    end
    checks++; if (full_out !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full_out); end
    checks++; if (count_out !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", count_out); end
    data_write_in = 8'h55;
    step();
    write_in = 1'b0;
    checks++; if (count_out !== 5'd16) begin errors++; $display("FAIL overfill_count got=%0d exp=16", count_out); end
    checks++; if (data_read_out !== 8'h10) begin errors++; $display("FAIL overfill_head got=%h exp=10", data_read_out); end
  endtask

  task automatic test_drain();
    read_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (data_read_out !== fill_v[i]) begin errors++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_read_out, fill_v[i]); end
      step();
    end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty_out); end
    checks++; if (data_read_out !== 8'h00) begin errors++; $display("FAIL drain_data_zero got=%h exp=00", data_read_out); end
    step();
    read_in = 1'b0;
    checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL underflow_count got=%0d exp=0", count_out); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL underflow_empty got=%b exp=1", empty_out); end
  endtask

  task automatic test_wrap();
    int peak;
    logic saw_full;
    peak = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      write_in = 1'b1; data_write_in = 8'h30 + 8'(i);
      step();
      if (full_out) saw_full = 1'b1;
      if (int'(count_out) > peak) peak = int'(count_out);
    end
    write_in = 1'b0; read_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (data_read_out !== 8'h30 + 8'(i)) begin errors++; $display("FAIL wrap_a_data i=%0d got=%h exp=%h", i, data_read_out, 8'h30 + 8'(i)); end
      step();
    end
    read_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      write_in = 1'b1; data_write_in = 8'h40 + 8'(i);
      step();
      if (full_out) saw_full = 1'b1;
      if (int'(count_out) > peak) peak = int'(count_out);
    end
    write_in = 1'b0; read_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++; if (data_read_out !== 8'h40 + 8'(i)) begin errors++; $display("FAIL wrap_b_data i=%0d got=%h exp=%h", i, data_read_out, 8'h40 + 8'(i)); end
      step();
    end
    read_in = 1'b0;
    checks++; if (saw_full !== 1'b0) begin errors++; $display("FAIL wrap_full_seen got=%b exp=0", saw_full); end
    checks++; if (peak != 12) begin errors++; $display("FAIL wrap_peak got=%0d exp=12", peak); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL wrap_end_empty got=%b exp=1", empty_out); end
  endtask

  task automatic test_simultaneous();
    // Empty: only the write lands.
    write_in = 1'b1; read_in = 1'b1; data_write_in = 8'h77;
    step();
    write_in = 1'b0; read_in = 1'b0;
    checks++; if (count_out !== 5'd1) begin errors++; $display("FAIL sim_empty_count got=%0d exp=1", count_out); end
    checks++; if (data_read_out !== 8'h77) begin errors++; $display("FAIL sim_empty_data got=%h exp=77", data_read_out); end
    read_in = 1'b1;
    step();
    read_in = 1'b0;
    // Full: only the read lands.
    for (int i = 0; i < 16; i++) begin
      write_in = 1'b1; data_write_in = 8'h60 + 8'(i);
      step();
    end
    read_in = 1'b1; data_write_in = 8'hee;
    step();
    write_in = 1'b0; read_in = 1'b0;
    checks++; if (count_out !== 5'd15) begin errors++; $display("FAIL sim_full_count got=%0d exp=15", count_out); end
    checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL sim_full_flag got=%b exp=0", full_out); end
    read_in = 1'b1;
    for (int i = 1; i < 16; i++) begin
      checks++; if (data_read_out !== 8'h60 + 8'(i)) begin errors++; $display("FAIL sim_full_data i=%0d got=%h exp=%h", i, data_read_out, 8'h60 + 8'(i)); end
      step();
    end
    read_in = 1'b0;
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL sim_full_drained got=%b exp=1", empty_out); end
    // Half-full: both land, occupancy steady.
    for (int i = 0; i < 8; i++) begin
      write_in = 1'b1; data_write_in = 8'h80 + 8'(i);
      step();
    end
    read_in = 1'b1;
    for (int j = 0; j < 4; j++) begin
      data_write_in = 8'h90 + 8'(j);
      step();
      checks++; if (count_out !== 5'd8) begin errors++; $display("FAIL sim_half_count j=%0d got=%0d exp=8", j, count_out); end
      checks++; if (data_read_out !== 8'h81 + 8'(j)) begin errors++; $display("FAIL sim_half_head j=%0d got=%h exp=%h", j, data_read_out, 8'h81 + 8'(j)); end
    end
    write_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp;
      exp = (i < 4) ? 8'h84 + 8'(i) : 8'h90 + 8'(i - 4);
      checks++; if (data_read_out !== exp) begin errors++; $display("FAIL sim_half_data i=%0d got=%h exp=%h", i, data_read_out, exp); end
      step();
    end
    read_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      write_in = 1'b1; data_write_in = 8'hc0 + 8'(i);
      step();
    end
    write_in = 1'b0;
    checks++; if (count_out !== 5'd7) begin errors++; $display("FAIL mid_pre_count got=%0d exp=7", count_out); end
    #2 nrst_in = 1'b0;
    #1;
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty_out); end
    checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL mid_full got=%b exp=0", full_out); end
    checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count_out); end
    checks++; if (data_read_out !== 8'h00) begin errors++; $display("FAIL mid_data got=%h exp=00", data_read_out); end
    #2 nrst_in = 1'b1;
    write_in = 1'b1; data_write_in = 8'ha5;
    step();
    write_in = 1'b0;
    checks++; if (data_read_out !== 8'ha5) begin errors++; $display("FAIL mid_after_data got=%h exp=a5", data_read_out); end
    checks++; if (count_out !== 5'd1) begin errors++; $display("FAIL mid_after_count got=%0d exp=1", count_out); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fill_v[0]  = 8'h10; fill_v[1]  = 8'h01; fill_v[2]  = 8'h91; fill_v[3]  = 8'hab;
    fill_v[4]  = 8'hba; fill_v[5]  = 8'haf; fill_v[6]  = 8'hfa; fill_v[7]  = 8'h22;
    fill_v[8]  = 8'h11; fill_v[9]  = 8'h99; fill_v[10] = 8'h11; fill_v[11] = 8'h00;
    fill_v[12] = 8'h13; fill_v[13] = 8'hff; fill_v[14] = 8'h25; fill_v[15] = 8'h23;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
